hamming_link_ctrl: RTL

Single-clock sequencer for the Hamming(7,4) serial link. It replaces the free-running slow clock with bit-rate enables derived from `clk_fast`, frames the 7-bit codeword stream, and drives the channel `error` line to inject single-bit faults on a programmable schedule. It also checks each decoder verdict against what was injected and keeps link statistics. It sits beside the encoder/channel/decoder datapath as its controller.

---
 rtl/hamming_pkg.sv | 16 +
 rtl/hamming_flag_fifo.sv | 67 ++++++
 rtl/hamming_link_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) serial-link controller slice.
//   FRAME_BITS   : codeword length in serial bits
//   DATA_BITS    : payload bits per codeword
//   link_state_t : sequencer states
package hamming_pkg;

  localparam int unsigned FRAME_BITS = 7;
  localparam int unsigned DATA_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } link_state_t;

endpackage

// File: rtl/hamming_flag_fifo.sv
// Two-entry, 1-bit FIFO that holds the injection flags of frames still
// waiting for a decoder verdict.
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the queue)
//   push_i, din_i : enqueue request and flag
//   pop_i         : dequeue request (ignored when empty)
//   dout_o        : flag at the head of the queue
//   full_o        : both entries occupied
//   empty_o       : no entries occupied
// A push while full is accepted only if a pop frees a slot on the same cycle.
module hamming_flag_fifo (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  logic [1:0] mem_q, mem_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_ok, pop_ok;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign dout_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/hamming_link_ctrl.sv
// Sequencer for the Hamming(7,4) serial link: bit-rate enables from clk_fast,
// codeword framing, scheduled single-bit fault injection, and verdict checking
// with saturating link statistics.
//   clk_fast, rst_n          : clock, asynchronous active-low reset
//   start, stop              : begin streaming (IDLE) / finish frame and drain (RUN)
//   inj_en/inj_pos/inj_period: fault-injection schedule, sampled per frame
//   dec_done, dec_syn_nz     : decoder verdict for the oldest outstanding frame
//   bit_en, frame_start,
//   frame_end, bit_idx       : bit timing and framing
//   error                    : channel fault line, aligned with bit_idx
//   busy                     : state is not IDLE
//   frame_cnt/inj_cnt/corr_cnt: saturating statistics
//   mismatch, ovf            : sticky verdict-mismatch / queue over-underflow
module hamming_link_ctrl
  import hamming_pkg::*;
#(
  parameter int unsigned DIV        = 4,
  parameter int unsigned FRAME_BITS = hamming_pkg::FRAME_BITS,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_fast,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             inj_en,
  input  logic [2:0]       inj_pos,
  input  logic [7:0]       inj_period,
  input  logic             dec_done,
  input  logic             dec_syn_nz,
  output logic             bit_en,
  output logic             frame_start,
  output logic             frame_end,
  output logic [2:0]       bit_idx,
  output logic             error,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] inj_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic             mismatch,
  output logic             ovf
);

  localparam int unsigned        DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [2:0]         BIT_LAST  = 3'(FRAME_BITS - 1);
  localparam logic [2:0]         POS_LIMIT = 3'(FRAME_BITS);

  link_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       pos_q, pos_d;
  logic             inj_this_q, inj_this_d;
  logic [7:0]       frame_mod_q, frame_mod_d;
  logic             stop_seen_q, stop_seen_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic             mismatch_q, mismatch_d;
  logic             ovf_q, ovf_d;
  logic             new_frame;

  logic fifo_head, fifo_full, fifo_empty, pop_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign bit_en      = (state_q == RUN) && (div_cnt_q == '0);
  assign frame_start = bit_en && (bit_idx_q == '0);
  assign frame_end   = bit_en && (bit_idx_q == BIT_LAST);
  assign bit_idx     = bit_idx_q;
  assign error       = error_q;
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign inj_cnt     = inj_cnt_q;
  assign corr_cnt    = corr_cnt_q;
  assign mismatch    = mismatch_q;
  assign ovf         = ovf_q;

  assign pop_ok = dec_done && !fifo_empty;

  hamming_flag_fifo u_flag_fifo (
    .clk_i   (clk_fast),
    .rst_ni  (rst_n),
    .push_i  (frame_end),
    .din_i   (inj_this_q),
    .pop_i   (dec_done),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer, prescaler and bit counter.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_seen_d = stop_seen_q;
    new_frame   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          div_cnt_d   = '0;
          bit_idx_d   = '0;
          stop_seen_d = 1'b0;
          new_frame   = 1'b1;
        end
      end
      RUN: begin
        if (stop) stop_seen_d = 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = '0;
            if (stop || stop_seen_q) begin
              state_d     = DRAIN;
              stop_seen_d = 1'b0;
            end else begin
              new_frame = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DRAIN: begin
        if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The injection decision is taken on the cycle that launches a frame, so the
  // registered error line can already be high in the frame_start cycle when
  // the selected bit is 0; the config is then frozen for the whole frame.
  always_comb begin
    pos_d       = pos_q;
    inj_this_d  = inj_this_q;
    frame_mod_d = frame_mod_q;
    if (new_frame) begin
      pos_d      = inj_pos;
      inj_this_d = inj_en && (inj_period != '0) &&
                   (frame_mod_q == inj_period - 8'd1) && (inj_pos < POS_LIMIT);
      if ((inj_period == '0) || (frame_mod_q >= inj_period - 8'd1)) begin
        frame_mod_d = '0;
      end else begin
        frame_mod_d = frame_mod_q + 8'd1;
      end
    end
    error_d = (state_d == RUN) && inj_this_d && (bit_idx_d == pos_d);
  end

  // Statistics and verdict checking.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    inj_cnt_d   = inj_cnt_q;
    corr_cnt_d  = corr_cnt_q;
    mismatch_d  = mismatch_q;
    ovf_d       = ovf_q;
    if (frame_end) begin
      frame_cnt_d = sat_inc(frame_cnt_q);
      if (inj_this_q) inj_cnt_d = sat_inc(inj_cnt_q);
      if (fifo_full && !pop_ok) ovf_d = 1'b1;
    end
    if (dec_done && fifo_empty) ovf_d = 1'b1;
    if (pop_ok) begin
      if (dec_syn_nz) corr_cnt_d = sat_inc(corr_cnt_q);
      if (dec_syn_nz != fifo_head) mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      pos_q       <= '0;
      inj_this_q  <= 1'b0;
      frame_mod_q <= '0;
      stop_seen_q <= 1'b0;
      error_q     <= 1'b0;
      frame_cnt_q <= '0;
      inj_cnt_q   <= '0;
      corr_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_idx_q   <= bit_idx_d;
      pos_q       <= pos_d;
      inj_this_q  <= inj_this_d;
      frame_mod_q <= frame_mod_d;
      stop_seen_q <= stop_seen_d;
      error_q     <= error_d;
      frame_cnt_q <= frame_cnt_d;
      inj_cnt_q   <= inj_cnt_d;
      corr_cnt_q  <= corr_cnt_d;
      mismatch_q  <= mismatch_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule
